// File: rtl/bcd_display_mux_if.sv
// bcd_display_mux_if: request/status and display bundle for bcd_display_mux.
// master drives start/bin/en; slave returns busy/done/seg/an.
interface bcd_display_mux_if #(
   parameter int W      = 4,
   parameter int DIGITS = 2
);
   logic              start;
   logic [W-1:0]      bin;
   logic              en;
   logic              busy;
   logic              done;
   logic [6:0]        seg;
   logic [DIGITS-1:0] an;

   modport master (
      output start, bin, en,
      input  busy, done, seg, an
   );

   modport slave (
      input  start, bin, en,
      output busy, done, seg, an
   );
endinterface

// File: rtl/bcd_display_mux.sv
// bcd_display_mux: shift-and-add-3 binary-to-BCD plus scanned 7-seg driver.
// Build option GRAY_INPUT_EN: treat bin as Gray code and convert on load.
module bcd_display_mux #(
   parameter int W           = 4,
   parameter int DIGITS      = 2,
   parameter int REFRESH_DIV = 100000
) (
   input logic              clk,
   input logic              rst,
   bcd_display_mux_if.slave bus
);
   localparam int BW   = 4 * DIGITS;
   localparam int CNTW = $clog2(W + 1);
   localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int RW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_LATCH = 2'd2;

   function automatic bit range_ok();
      longint unsigned p;
      p = 1;
      for (int i = 0; i < DIGITS; i++) p = p * 10;
      return p > ((64'd1 << W) - 64'd1);
   endfunction

   if (!range_ok()) begin : g_range_err
      $error("bcd_display_mux: DIGITS too small for W");
   end

   logic [1:0]        r_state;
   logic [W-1:0]      r_sh;
   logic [BW-1:0]     r_bcd;
   logic [CNTW-1:0]   r_cnt;
   logic [BW-1:0]     r_disp;
   logic [RW-1:0]     r_ref;
   logic [IW-1:0]     r_idx;
   logic [6:0]        r_seg;
   logic [DIGITS-1:0] r_an;

   logic [W-1:0]      w_bin;
   logic [BW-1:0]     w_adj;
   logic [BW-1:0]     w_bcd_nx;
   logic [W-1:0]      w_sh_nx;
   logic [3:0]        w_nib;
   logic [6:0]        w_dec;
   logic [DIGITS-1:0] w_onehot;

`ifdef GRAY_INPUT_EN
   // Gray to binary: each bit is the XOR of all Gray bits at or above it
   always_comb begin
      w_bin = '0;
      for (int i = 0; i < W; i++) w_bin[i] = ^(bus.bin >> i);
   end
`else
   assign w_bin = bus.bin;
`endif

   // add 3 to every BCD nibble that is 5 or more before the shift
   always_comb begin
      w_adj = r_bcd;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_bcd[4*d +: 4] >= 4'd5)
            w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
   end

   assign {w_bcd_nx, w_sh_nx} = {w_adj, r_sh} << 1;

   // conversion FSM; the display only takes the finished result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_sh    <= '0;
         r_bcd   <= '0;
         r_cnt   <= '0;
         r_disp  <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_sh    <= w_bin;
                  r_bcd   <= '0;
                  r_cnt   <= CNTW'(W);
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_bcd <= w_bcd_nx;
               r_sh  <= w_sh_nx;
               r_cnt <= r_cnt - CNTW'(1);
               if (r_cnt == CNTW'(1)) begin
                  r_disp  <= w_bcd_nx;
                  r_state <= S_LATCH;
               end
            end
            S_LATCH: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy = (r_state == S_SHIFT);
   assign bus.done = (r_state == S_LATCH);

   // free-running refresh counter steps the scanned digit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ref <= '0;
         r_idx <= '0;
      end else if (r_ref == RW'(REFRESH_DIV - 1)) begin
         r_ref <= '0;
         if (r_idx == IW'(DIGITS - 1))
            r_idx <= '0;
         else
            r_idx <= r_idx + IW'(1);
      end else begin
         r_ref <= r_ref + RW'(1);
      end
   end

   assign w_nib    = r_disp[r_idx*4 +: 4];
   assign w_onehot = DIGITS'(1) << r_idx;

   // active-low segment decode of the current digit
   always_comb begin
      w_dec = 7'b1111111;
      unique case (w_nib)
         4'd0:    w_dec = 7'b0000001;
         4'd1:    w_dec = 7'b1001111;
         4'd2:    w_dec = 7'b0010010;
         4'd3:    w_dec = 7'b0000110;
         4'd4:    w_dec = 7'b1001100;
         4'd5:    w_dec = 7'b0100100;
         4'd6:    w_dec = 7'b0100000;
         4'd7:    w_dec = 7'b0001111;
         4'd8:    w_dec = 7'b0000000;
         4'd9:    w_dec = 7'b0000100;
         default: w_dec = 7'b1111111;
      endcase
   end

   // register segments and anodes together so they never disagree
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_seg <= 7'b1111111;
         r_an  <= '1;
      end else begin
         r_seg <= w_dec;
         r_an  <= bus.en ? ~w_onehot : '1;
      end
   end

   assign bus.seg = r_seg;
   assign bus.an  = r_an;
endmodule

// File: tb/tb_bcd_display_mux.sv
// tb_bcd_display_mux: directed bench for two bcd_display_mux builds.
// Instance a: W=4/DIGITS=2, instance b: W=8/DIGITS=3, REFRESH_DIV=4.
module tb_bcd_display_mux;
   logic clk = 1'b0;
   logic rst;
   int   chk = 0;
   int   err = 0;

   always #5 clk = ~clk;

   bcd_display_mux_if #(.W(4), .DIGITS(2)) ifa ();
   bcd_display_mux_if #(.W(8), .DIGITS(3)) ifb ();

   bcd_display_mux #(.W(4), .DIGITS(2), .REFRESH_DIV(4)) u_a (
      .clk(clk), .rst(rst), .bus(ifa)
   );
   bcd_display_mux #(.W(8), .DIGITS(3), .REFRESH_DIV(4)) u_b (
      .clk(clk), .rst(rst), .bus(ifb)
   );

   function automatic logic [6:0] seg_of(input int n);
      case (n)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         9: return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [7:0] enc(input logic [7:0] v);
`ifdef GRAY_INPUT_EN
      return v ^ (v >> 1);
`else
      return v;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      chk++;
      assert (obs === exp) else begin
         err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic conv_a_raw(input logic [3:0] b, input string tag);
      ifa.start = 1'b1;
      ifa.bin   = b;
      step();
      ifa.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check({tag, "_busy"}, ifa.busy, 1);
         check({tag, "_nodone"}, ifa.done, 0);
         step();
      end
      check({tag, "_done"}, ifa.done, 1);
      check({tag, "_busyfall"}, ifa.busy, 0);
      step();
      check({tag, "_donepulse"}, ifa.done, 0);
   endtask

   task automatic conv_a(input int v, input string tag);
      logic [7:0] e;
      e = enc(8'(v));
      conv_a_raw(e[3:0], tag);
   endtask

   task automatic conv_b(input int v, input string tag);
      ifb.start = 1'b1;
      ifb.bin   = enc(8'(v));
      step();
      ifb.start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check({tag, "_busy"}, ifb.busy, 1);
         step();
      end
      check({tag, "_done"}, ifb.done, 1);
      check({tag, "_busyfall"}, ifb.busy, 0);
      step();
      check({tag, "_donepulse"}, ifb.done, 0);
   endtask

   task automatic digits_a(input int t, input int u, input string tag);
      logic [1:0] pat;
      bit found;
      for (int d = 0; d < 2; d++) begin
         pat   = ~(2'b01 << d);
         found = 0;
         for (int k = 0; k < 16 && !found; k++) begin
            if (ifa.an === pat) found = 1;
            else step();
         end
         check({tag, "_scan"}, found, 1);
         check({tag, "_seg"}, ifa.seg, seg_of(d == 0 ? u : t));
      end
   endtask

   task automatic digits_b(input int h, input int t, input int u,
                           input string tag);
      logic [2:0] pat;
      bit found;
      for (int d = 0; d < 3; d++) begin
         pat   = ~(3'b001 << d);
         found = 0;
         for (int k = 0; k < 24 && !found; k++) begin
            if (ifb.an === pat) found = 1;
            else step();
         end
         check({tag, "_scan"}, found, 1);
         check({tag, "_seg"}, ifb.seg,
               seg_of(d == 0 ? u : (d == 1 ? t : h)));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      bit   found;
      logic [1:0] prev;

      rst       = 1'b1;
      ifa.start = 1'b0;
      ifa.bin   = '0;
      ifa.en    = 1'b1;
      ifb.start = 1'b0;
      ifb.bin   = '0;
      ifb.en    = 1'b1;

      step();
      check("rst_seg", ifa.seg, 7'b1111111);
      check("rst_an", ifa.an, 2'b11);
      check("rst_busy", ifa.busy, 0);
      check("rst_done", ifa.done, 0);
      check("rst_an_b", ifb.an, 3'b111);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         step();
         check("scan_an", ifa.an, (i < 4) ? 2'b10 : 2'b01);
         check("scan_seg0", ifa.seg, 7'b0000001);
      end

      conv_a(13, "a13");
      digits_a(1, 3, "d13");

      conv_a(15, "a15");
      conv_a(13, "b2b");
      digits_a(1, 3, "d13b");

      ifa.start = 1'b1;
      ifa.bin   = 4'(enc(8'd9));
      step();
      ifa.start = 1'b0;
      step();
      ifa.start = 1'b1;
      ifa.bin   = 4'(enc(8'd7));
      step();
      ifa.start = 1'b0;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         if (ifa.done) n++;
         step();
      end
      check("ign_done_cnt", n, 1);
      digits_a(0, 9, "d09");

      found = 0;
      prev  = ifa.an;
      for (int k = 0; k < 16 && !found; k++) begin
         step();
         if (prev === 2'b10 && ifa.an === 2'b01) found = 1;
         prev = ifa.an;
      end
      check("en_sync", found, 1);
      ifa.en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         check("en0_an", ifa.an, 2'b11);
      end
      ifa.en = 1'b1;
      step();
      check("en1_an0", ifa.an, 2'b10);
      step();
      check("en1_an1", ifa.an, 2'b01);

      ifa.start = 1'b1;
      ifa.bin   = 4'(enc(8'd9));
      step();
      ifa.start = 1'b0;
      step();
      check("mid_busy", ifa.busy, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", ifa.busy, 0);
      check("mid_rst_done", ifa.done, 0);
      step();
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (ifa.done) n++;
      end
      check("mid_no_done", n, 0);
      check("mid_idle", ifa.busy, 0);
      digits_a(0, 0, "d00");

      conv_b(255, "b255");
      digits_b(2, 5, 5, "d255");
      conv_b(0, "b0");
      digits_b(0, 0, 0, "d000");

`ifdef GRAY_INPUT_EN
      conv_a_raw(4'b1011, "gray");
      digits_a(1, 3, "dgray");
`endif

      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end
endmodule

// File: doc/bcd_display_mux.md
Name: bcd_display_mux

Overview:
Sequential binary-to-BCD converter with a time-multiplexed seven-segment driver, parametrised in input width and digit count. Accepts a W-bit binary value on a start pulse and converts it by shift-and-add-3, one shift per clock. The result is latched into a display register and scanned across DIGITS common-anode digits on the Basys3 display. Replaces fixed 2-digit combinational display decode in the Gray-code demo datapath.

Parameters:
W, 4, width of binary input value
DIGITS, 2, number of BCD digits driven; must satisfy 10^DIGITS > 2^W-1 (checked at elaboration, $error otherwise)
REFRESH_DIV, 100000, clock cycles each digit stays active (1 kHz per digit at 100 MHz)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle request to convert bin
bin  input  W  binary value; sampled only on accepted start
en  input  1  display enable; 0 blanks all anodes
busy  output  1  high while conversion in progress
done  output  1  one-cycle pulse when new value latched to display
seg  output  7  segments {a,b,c,d,e,f,g}, active-low (seg[6]=a, seg[0]=g)
an  output  DIGITS  digit anodes, active-low, one-hot-low when enabled; an[0]=units

Behaviour:
- One clock: clk. Reset asynchronous, active-high: rst.
- Reset values: seg=7'b1111111, an=all ones, busy=0, done=0, display register=0, shift/BCD regs=0, digit index=0, refresh counter=0, FSM=IDLE.
- FSM states: IDLE, SHIFT, LATCH.
- IDLE: start=1 -> load bin into shift reg, clear BCD reg (4*DIGITS bits), shift count=W, busy=1, go SHIFT. start=0 -> stay.
- SHIFT: each cycle, every BCD nibble >=5 gets +3, then {BCD,shift reg} shifts left 1; count decrements; after W shifts go LATCH.
- LATCH: copy BCD reg into display register, done=1 for this cycle only, busy=0, go IDLE.
- Latency: start sampled at edge 0 -> done high in cycle W+1; busy high cycles 1..W+1 minus LATCH (busy falls with done). Back-to-back start accepted the cycle after done.
- start while busy ignored; bin changes during conversion have no effect.
- Display register holds previous value until LATCH; no intermediate BCD values ever displayed.
- Refresh counter counts 0..REFRESH_DIV-1 continuously (independent of en); at terminal count wraps to 0 and digit index advances, DIGITS-1 wraps to 0.
- an: en=1 -> bit [digit index] low, others high; en=0 -> all high. seg registered from current digit nibble; seg and an update on same edge.
- Decode (active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; any other nibble -> 1111111.
- rst mid-conversion: abort, IDLE, display register=0, no done pulse.

Optional Feature:
GRAY_INPUT_EN: defined -> bin is Gray code; converted to binary (MSB copied, bin[i]=bin[i+1]^gray[i]) combinationally before load at start; latency unchanged. Not defined -> bin used as plain binary.

Test Plan:
Reset with en=1, REFRESH_DIV=4 -> seg=0000001 on every digit, an cycles 10,01 every 4 clocks (DIGITS=2).
W=4, start with bin=4'd13 -> busy 1 for 4 cycles, done pulse at cycle 5, digits show 1 (tens) and 3 (units): seg 1001111 / 0000110.
W=8, DIGITS=3, bin=8'd255 -> done at cycle 9, digits 2,5,5; bin=0 then shows 0,0,0.
start asserted again during busy with bin=4'd7 after start with 4'd9 -> only one done, display 09.
en=0 -> an all ones while refresh counter keeps running; en=1 resumes on current digit index.
rst pulsed mid-SHIFT -> busy=0, no done, display 00; GRAY_INPUT_EN defined, bin=4'b1011 -> displays 13.
